// File: rtl/multicore_pkg.sv
// Shared types and default sizes for the multicore prime-count result path.
package multicore_pkg;

   // Collector phases: wait for all cores, add results one by one, then hold.
   typedef enum logic [1:0] {
      COL_RUN  = 2'd0,
      COL_SUM  = 2'd1,
      COL_DONE = 2'd2
   } col_state_t;

   localparam int MAX_CORES     = 8;
   localparam int IDX_W         = $clog2(MAX_CORES);
   localparam int DEF_NUM_CORES = 4;
   localparam int DEF_DATA_W    = 8;
   localparam int DEF_SUM_W     = 8;
   localparam int DEF_CYC_W     = 16;

endpackage

// File: rtl/strobe_fall_detect.sv
// One core's strobe history bit and its falling-edge pulse.
// The history bit clears in reset, so a strobe already high at reset
// release only reports once it later falls.
module strobe_fall_detect (
   input  logic clk,
   input  logic reset,
   input  logic strobe,
   output logic fall
);

   logic strobe_q;

   // Remember last cycle's strobe level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) strobe_q <= 1'b0;
      else        strobe_q <= strobe;
   end

   assign fall = strobe_q & ~strobe;

endmodule

// File: rtl/core_result_collector.sv
// Collects one result per core on its strobe's falling edge, counts cycles
// until all cores have reported, then sums the results one per cycle and
// holds the total for the display.
// Optional watchdog: define COLLECT_TIMEOUT_EN to abandon waiting after
// TIMEOUT_CYCLES cycles and sum whatever has been reported.
module core_result_collector
   import multicore_pkg::*;
#(
   parameter int          NUM_CORES      = DEF_NUM_CORES,
   parameter int          DATA_W         = DEF_DATA_W,
   parameter int          SUM_W          = DEF_SUM_W,
   parameter int          CYC_W          = DEF_CYC_W,
   parameter int unsigned TIMEOUT_CYCLES = 32'h0000_FFF0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_CORES-1:0]        core_strobe,
   input  logic [NUM_CORES*DATA_W-1:0] core_result,
   output logic [NUM_CORES-1:0]        done_mask,
   output logic [CYC_W-1:0]            cycle_count,
   output logic [SUM_W-1:0]            total,
   output logic                        total_valid,
   output logic                        sum_ovf,
   output logic                        timeout
);

   localparam logic [NUM_CORES-1:0] ALL_DONE = '1;
   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_CORES - 1);

`ifdef COLLECT_TIMEOUT_EN
   localparam logic [CYC_W-1:0]     TIMEOUT_LIMIT = CYC_W'(TIMEOUT_CYCLES);
`endif

   col_state_t                  state_reg;
   logic [IDX_W-1:0]            idx_reg;
   logic [NUM_CORES-1:0]        fall;
   logic [NUM_CORES-1:0]        capture;
   logic [NUM_CORES*DATA_W-1:0] results_flat;
   logic [DATA_W-1:0]           result_sel;
   logic [SUM_W:0]              sum_next;

   // Only the first fall of each core counts, and only while still collecting.
   assign capture = fall & ~done_mask & {NUM_CORES{state_reg == COL_RUN}};

   generate
      for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
         logic [DATA_W-1:0] result_reg;

         strobe_fall_detect u_fall (
            .clk    (clk),
            .reset  (reset),
            .strobe (core_strobe[gi]),
            .fall   (fall[gi])
         );

         // Freeze this core's result on its first reported fall.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset)           result_reg <= '0;
            else if (capture[gi]) result_reg <= core_result[gi*DATA_W +: DATA_W];
         end

         assign results_flat[gi*DATA_W +: DATA_W] = result_reg;
      end
   endgenerate

   // Select the result addressed by the summing index.
   always_comb begin
      result_sel = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (idx_reg == IDX_W'(i)) result_sel = results_flat[i*DATA_W +: DATA_W];
      end
   end

   // Extra top bit is the carry out used for the sticky overflow flag.
   assign sum_next = {1'b0, total} + {1'b0, SUM_W'(result_sel)};

   // Collector FSM with cycle counter and sequential accumulator.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= COL_RUN;
         idx_reg     <= '0;
         done_mask   <= '0;
         cycle_count <= '0;
         total       <= '0;
         total_valid <= 1'b0;
         sum_ovf     <= 1'b0;
`ifdef COLLECT_TIMEOUT_EN
         timeout     <= 1'b0;
`endif
      end else begin
         done_mask <= done_mask | capture;
         case (state_reg)
            COL_RUN: begin
               if (done_mask == ALL_DONE) begin
                  state_reg <= COL_SUM;
`ifdef COLLECT_TIMEOUT_EN
               end else if (cycle_count == TIMEOUT_LIMIT) begin
                  // Unreported cores still hold zero, so they add nothing.
                  timeout   <= 1'b1;
                  state_reg <= COL_SUM;
`endif
               end else if (cycle_count != '1) begin
                  cycle_count <= cycle_count + CYC_W'(1);
               end
            end
            COL_SUM: begin
               total <= sum_next[SUM_W-1:0];
               if (sum_next[SUM_W]) sum_ovf <= 1'b1;
               if (idx_reg == LAST_IDX) begin
                  state_reg   <= COL_DONE;
                  total_valid <= 1'b1;
               end else begin
                  idx_reg <= idx_reg + IDX_W'(1);
               end
            end
            COL_DONE: begin
               // Hold everything until the next reset.
            end
            default: state_reg <= COL_RUN;
         endcase
      end
   end

`ifndef COLLECT_TIMEOUT_EN
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_core_result_collector.sv
// Scoreboard bench for core_result_collector: stimulus pushes expected
// done_mask steps and final results; a monitor pops them when the DUT
// changes done_mask or raises total_valid.
module tb_core_result_collector;

   localparam int NC = 4;
   localparam int DW = 8;
   localparam int SW = 8;
   localparam int CW = 16;
`ifdef COLLECT_TIMEOUT_EN
   localparam int unsigned TO_CYC = 20;
`else
   localparam int unsigned TO_CYC = 32'h0000_FFF0;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [NC-1:0]    core_strobe;
   logic [NC*DW-1:0] core_result;
   logic [NC-1:0]    done_mask;
   logic [CW-1:0]    cycle_count;
   logic [SW-1:0]    total;
   logic             total_valid;
   logic             sum_ovf;
   logic             timeout;

   core_result_collector #(
      .NUM_CORES(NC), .DATA_W(DW), .SUM_W(SW), .CYC_W(CW), .TIMEOUT_CYCLES(TO_CYC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .core_strobe (core_strobe),
      .core_result (core_result),
      .done_mask   (done_mask),
      .cycle_count (cycle_count),
      .total       (total),
      .total_valid (total_valid),
      .sum_ovf     (sum_ovf),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   typedef struct { int e; logic [NC-1:0] stb; logic [NC*DW-1:0] res; } ev_t;
   typedef struct { int e; logic [NC-1:0] mask; } mask_exp_t;
   typedef struct { int e; logic [SW-1:0] tot; logic ovf; logic [CW-1:0] cyc;
                    logic [NC-1:0] mask; logic to; } fin_exp_t;

   ev_t       evq[$];
   mask_exp_t mask_q[$];
   fin_exp_t  fin_q[$];

   int n_vec  = 0;
   int n_miss = 0;
   int edge_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   // Edge 1 is the first rising edge after reset release.
   always @(posedge clk) begin
      if (!reset) edge_cnt = 0;
      else        edge_cnt++;
   end

   // Monitor: compare every done_mask step and every total_valid rise.
   logic [NC-1:0] prev_mask  = '0;
   logic          prev_valid = 1'b0;
   mask_exp_t     mon_m;
   fin_exp_t      mon_f;
   always @(negedge clk) begin
      if (reset) begin
         if (done_mask !== prev_mask) begin
            if (mask_q.size() == 0) begin
               check("unexpected_mask_change", 32'(done_mask), 32'(prev_mask));
            end else begin
               mon_m = mask_q.pop_front();
               check("mask_edge", edge_cnt, mon_m.e);
               check("mask", 32'(done_mask), 32'(mon_m.mask));
            end
         end
         if (total_valid && !prev_valid) begin
            if (fin_q.size() == 0) begin
               check("unexpected_valid", 32'(total_valid), 32'd0);
            end else begin
               mon_f = fin_q.pop_front();
               check("valid_edge", edge_cnt, mon_f.e);
               check("total", 32'(total), 32'(mon_f.tot));
               check("sum_ovf", 32'(sum_ovf), 32'(mon_f.ovf));
               check("cycle_count", 32'(cycle_count), 32'(mon_f.cyc));
               check("final_mask", 32'(done_mask), 32'(mon_f.mask));
               check("timeout", 32'(timeout), 32'(mon_f.to));
            end
         end
      end
      prev_mask  = done_mask;
      prev_valid = total_valid;
   end

   task automatic add_ev(input int e, input logic [NC-1:0] stb, input logic [NC*DW-1:0] res);
      ev_t v;
      v.e = e; v.stb = stb; v.res = res;
      evq.push_back(v);
   endtask

   task automatic exp_mask(input int e, input logic [NC-1:0] mask);
      mask_exp_t m;
      m.e = e; m.mask = mask;
      mask_q.push_back(m);
   endtask

   task automatic exp_fin(input int e, input logic [SW-1:0] tot, input logic ovf,
                          input logic [CW-1:0] cyc, input logic [NC-1:0] mask, input logic to);
      fin_exp_t f;
      f.e = e; f.tot = tot; f.ovf = ovf; f.cyc = cyc; f.mask = mask; f.to = to;
      fin_q.push_back(f);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // Drive scheduled events so each is sampled at its edge; bounded by last_edge.
   task automatic run(input int last_edge);
      while (edge_cnt < last_edge) begin
         foreach (evq[k]) begin
            if (evq[k].e == edge_cnt + 1) begin
               core_strobe = evq[k].stb;
               core_result = evq[k].res;
            end
         end
         @(negedge clk);
      end
      evq.delete();
      check("pending_mask_events", mask_q.size(), 0);
      check("pending_final_events", fin_q.size(), 0);
      mask_q.delete();
      fin_q.delete();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_done_mask"}, 32'(done_mask), 0);
      check({tag, "_cycle_count"}, 32'(cycle_count), 0);
      check({tag, "_total"}, 32'(total), 0);
      check({tag, "_total_valid"}, 32'(total_valid), 0);
      check({tag, "_sum_ovf"}, 32'(sum_ovf), 0);
      check({tag, "_timeout"}, 32'(timeout), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      core_strobe = '0;
      core_result = '0;
      do_reset();
      check_all_zero("reset");

`ifdef COLLECT_TIMEOUT_EN
      // Watchdog: only cores 0 and 1 report (5, 6).
      add_ev(2, 4'b0011, {8'd0, 8'd0, 8'd6, 8'd5});
      add_ev(5, 4'b0000, {8'd0, 8'd0, 8'd6, 8'd5});
      exp_mask(5, 4'b0011);
      exp_fin(25, 8'd11, 1'b0, 16'd20, 4'b0011, 1'b1);
      run(30);
      do_reset();
`endif

      // Basic run: results {14,13,14,13}, falls at 5, 9, 9, 12; strobes after DONE are ignored.
      add_ev(2,  4'b1111, {8'd13, 8'd14, 8'd13, 8'd14});
      add_ev(5,  4'b1110, {8'd13, 8'd14, 8'd13, 8'd14});
      add_ev(9,  4'b0100, {8'd13, 8'd14, 8'd13, 8'd14});
      add_ev(12, 4'b0000, {8'd13, 8'd14, 8'd13, 8'd14});
      add_ev(20, 4'b0001, {8'd99, 8'd99, 8'd99, 8'd99});
      add_ev(22, 4'b0000, {8'd99, 8'd99, 8'd99, 8'd99});
      exp_mask(5,  4'b0001);
      exp_mask(9,  4'b1011);
      exp_mask(12, 4'b1111);
      exp_fin(17, 8'h36, 1'b0, 16'd12, 4'b1111, 1'b0);
      run(26);
      check("hold_total_valid", 32'(total_valid), 1);
      check("hold_total", 32'(total), 32'h36);
      check("hold_cycle_count", 32'(cycle_count), 12);

      // Core 2 strobes twice (7 then 9): only the first value is kept.
      do_reset();
      add_ev(2,  4'b0100, {8'd3, 8'd7, 8'd2, 8'd1});
      add_ev(4,  4'b0000, {8'd3, 8'd7, 8'd2, 8'd1});
      add_ev(6,  4'b1111, {8'd3, 8'd9, 8'd2, 8'd1});
      add_ev(8,  4'b1011, {8'd3, 8'd9, 8'd2, 8'd1});
      add_ev(10, 4'b0000, {8'd3, 8'd9, 8'd2, 8'd1});
      exp_mask(4,  4'b0100);
      exp_mask(10, 4'b1111);
      exp_fin(15, 8'd13, 1'b0, 16'd10, 4'b1111, 1'b0);
      run(18);

      // Strobes high through reset release: core 0 reports at edge 3, not edge 1.
      core_strobe = 4'b1111;
      core_result = {8'd8, 8'd7, 8'd6, 8'd5};
      do_reset();
      add_ev(3, 4'b1110, {8'd8, 8'd7, 8'd6, 8'd5});
      add_ev(6, 4'b0000, {8'd8, 8'd7, 8'd6, 8'd5});
      exp_mask(3, 4'b0001);
      exp_mask(6, 4'b1111);
      exp_fin(11, 8'd26, 1'b0, 16'd6, 4'b1111, 1'b0);
      run(14);

      // Overflow: {200,100,0,0} wraps to 44 with sticky carry.
      do_reset();
      add_ev(2, 4'b1111, {8'd0, 8'd0, 8'd100, 8'd200});
      add_ev(3, 4'b0000, {8'd0, 8'd0, 8'd100, 8'd200});
      exp_mask(3, 4'b1111);
      exp_fin(8, 8'd44, 1'b1, 16'd3, 4'b1111, 1'b0);
      run(12);

      // Reset mid-run with done_mask=0011: immediate clear, then a fresh run.
      do_reset();
      add_ev(2, 4'b0011, {8'd4, 8'd3, 8'd2, 8'd1});
      add_ev(4, 4'b0000, {8'd4, 8'd3, 8'd2, 8'd1});
      exp_mask(4, 4'b0011);
      run(6);
      check("pre_reset_mask", 32'(done_mask), 32'b0011);
      reset = 1'b0;
      #1;
      check_all_zero("async_reset");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      add_ev(2, 4'b1111, {8'd4, 8'd3, 8'd2, 8'd1});
      add_ev(4, 4'b0000, {8'd4, 8'd3, 8'd2, 8'd1});
      exp_mask(4, 4'b1111);
      exp_fin(9, 8'd10, 1'b0, 16'd4, 4'b1111, 1'b0);
      run(12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
